walk_seq_ctrl: RTL
==================

WALK_SEQ_CTRL -- requirements
Module: walk_seq_ctrl

Interface
REQ-001 Parameter N, default 32, is the walk vector width; the legal range is 1..32.
REQ-002 clk  input  1  rising-edge clock; the only clock domain.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  walk request, sampled on each rising edge of clk.
REQ-005 abort  input  1  terminates the walk in progress.
REQ-006 trig_out  output  1  asserted for one cycle, coincident with the first walk step.
REQ-007 vect  output  N  one-hot walk vector; all-zero when no walk is running.
REQ-008 busy  output  1  high for every cycle in which vect is non-zero.
REQ-009 done  output  1  asserted for one cycle, coincident with vect[0].
REQ-010 pend  output  1  a queued start is held; tied to 0 when the Configuration feature is absent.

Function
REQ-011 When N<1 or N>32, elaboration SHALL fail via $error("Parameter N has an invalid value of %0d", N).
REQ-012 The block has two states, IDLE and RUN, plus an internal step counter of width $clog2(N)+1.
REQ-013 In IDLE, start=1 and abort=0 at cycle c: the block enters RUN in cycle c+1 with vect=1<<(N-1), trig_out=1 and busy=1.
REQ-014 Each subsequent RUN cycle shifts vect right by one bit.
- vect[k] is high in cycle c+N-k.
- trig_out=0 in every RUN cycle after the first.
REQ-015 In cycle c+N, vect[0]=1 and done=1; in cycle c+N+1 the block is in IDLE with vect=0, busy=0 and done=0, unless REQ-019 applies.
REQ-016 The walk guarantees the downstream property: trig_out |-> vect[N-1] ##1 vect[N-2] ... ##1 vect[0].
REQ-017 When N=1, trig_out, vect[0] and done are all high in the single RUN cycle.
REQ-018 Without the Configuration feature, start is ignored while busy=1, including the done cycle.
REQ-019 abort=1 in any RUN cycle, including the done cycle, returns the block to IDLE in the next cycle:
- vect=0, busy=0, pend=0;
- no later done is produced for the aborted walk.
REQ-020 abort=1 and start=1 together in IDLE: abort wins, and no walk starts.
REQ-021 abort in IDLE without start has no effect.
REQ-022 vect is never multi-hot, and no output is driven X after reset.

Reset
REQ-023 rst=1 at a rising edge forces, from the next cycle, state IDLE, vect=0, trig_out=0, busy=0, done=0, pend=0 and step counter=0.
REQ-024 rst takes priority over start and abort.
REQ-025 rst asserted mid-walk truncates the walk silently, with no done pulse.
REQ-026 start sampled in the same cycle that rst is high is discarded.

Configuration
REQ-027 Macro WALK_SEQ_PEND_EN selects a one-deep start queue.
REQ-028 With WALK_SEQ_PEND_EN defined:
- start=1 while busy=1 and abort=0 sets pend from the next cycle;
- multiple starts collapse into one queued start.
REQ-029 With WALK_SEQ_PEND_EN defined, at the done cycle with pend=1, or with start=1 in the done cycle, the next cycle begins a new walk per REQ-013 and clears pend.
- The new walk has trig_out=1 and vect=1<<(N-1), with zero idle cycles between walks.
REQ-030 Without WALK_SEQ_PEND_EN, pend is constant 0 and REQ-018 applies.

Verification
REQ-031 N=32, reset, then start pulse in cycle 5 -> trig_out and vect=32'h8000_0000 in cycle 6; vect=32'h0000_0001 and done in cycle 37; vect=0 in cycle 38.
REQ-032 N=32, start in cycle 5, abort in cycle 15 -> vect=0 and busy=0 in cycle 16, and done never asserts.
REQ-033 N=32, start in cycle 5, rst in cycle 20 -> all outputs 0 from cycle 21; a start in cycle 21 is accepted and gives trig_out in cycle 22.
REQ-034 N=32, start in cycles 5 and 12:
- without the macro, exactly one walk runs and done occurs only in cycle 37;
- with WALK_SEQ_PEND_EN, pend=1 in cycles 13..37, trig_out in cycle 38, and done in cycle 69.
REQ-035 N=1, start in cycle 3 -> trig_out, vect=1 and done all in cycle 4; idle in cycle 5. Start and abort together in IDLE -> no walk.
REQ-036 Elaborating with N=0 and with N=33 -> an elaboration error is reported in both cases.

Source files
------------

// File: rtl/walk_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : walk_seq_ctrl_if
// Description : Request/response bundle for the walking-one sequencer.
//               The master drives start/abort; the slave (sequencer) drives
//               the trigger, walk vector and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface walk_seq_ctrl_if #(
  parameter int N = 32
);
  logic         start;
  logic         abort;
  logic         trig_out;
  logic [N-1:0] vect;
  logic         busy;
  logic         done;
  logic         pend;

  modport master (
    output start, abort,
    input  trig_out, vect, busy, done, pend
  );

  modport slave (
    input  start, abort,
    output trig_out, vect, busy, done, pend
  );
endinterface
`default_nettype wire

// File: rtl/walk_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : walk_seq_ctrl
// Description : Walking-one sequencer. A start request launches a one-hot
//               vector at the MSB that moves one bit right per cycle until it
//               reaches bit 0 (done). Abort or reset ends a walk silently.
//               Optional macro WALK_SEQ_PEND_EN adds a one-deep start queue so
//               back-to-back walks run with no idle cycle in between.
// Revision    : 1.0 - initial release
// ============================================================================
module walk_seq_ctrl #(
  parameter int N = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  walk_seq_ctrl_if.slave   walk
);

  // Reject widths outside 1..32 at elaboration time.
  generate
    if ((N < 1) || (N > 32)) begin : g_bad_n
      $error("Parameter N has an invalid value of %0d", N);
    end
  endgenerate

  localparam int           c_CW   = $clog2(N) + 1;
  localparam logic [N-1:0] c_TOP  = N'(1) << (N - 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

`ifdef WALK_SEQ_PEND_EN
  localparam bit c_PEND_EN = 1'b1;
`else
  localparam bit c_PEND_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_vect,  w_vect_nxt;
  logic [c_CW-1:0] r_cnt,   w_cnt_nxt;   // steps remaining after this one
  logic            r_trig,  w_trig_nxt;
  logic            r_pend,  w_pend_nxt;
  logic            w_last;

  // The final step of a walk is the cycle whose remaining-step count is zero.
  assign w_last = (r_state == S_RUN) && (r_cnt == '0);

  // State, vector, counter and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vect  <= '0;
      r_cnt   <= '0;
      r_trig  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vect  <= w_vect_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trig  <= w_trig_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Next-state logic: launch, shift, finish, abort and optional requeue.
  always_comb begin
    w_state_nxt = r_state;
    w_vect_nxt  = r_vect;
    w_cnt_nxt   = r_cnt;
    w_trig_nxt  = 1'b0;
    w_pend_nxt  = r_pend;

    case (r_state)
      S_IDLE: begin
        // Abort in the same cycle as start suppresses the launch.
        if (walk.start && !walk.abort) begin
          w_state_nxt = S_RUN;
          w_vect_nxt  = c_TOP;
          w_cnt_nxt   = c_LAST;
          w_trig_nxt  = 1'b1;
        end
      end

      S_RUN: begin
        if (walk.abort) begin
          w_state_nxt = S_IDLE;
          w_vect_nxt  = '0;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end else if (w_last) begin
          if (c_PEND_EN && (r_pend || walk.start)) begin
            // Chain straight into the queued walk with no idle gap.
            w_state_nxt = S_RUN;
            w_vect_nxt  = c_TOP;
            w_cnt_nxt   = c_LAST;
            w_trig_nxt  = 1'b1;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_vect_nxt  = '0;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_vect_nxt = r_vect >> 1;
          w_cnt_nxt  = r_cnt - 1'b1;
          // Any number of starts mid-walk collapse into one queued request.
          if (c_PEND_EN && walk.start) begin
            w_pend_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_vect_nxt  = '0;
        w_cnt_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  assign walk.trig_out = r_trig;
  assign walk.vect     = r_vect;
  assign walk.busy     = (r_state == S_RUN);
  assign walk.done     = w_last;
  assign walk.pend     = r_pend;

endmodule
`default_nettype wire
